isqrt_seq: RTL and testbench
============================

# isqrt_seq

Sequential integer square-root unit, the inverse companion of the squaring datapath: it takes one signed operand and produces its floor square root and remainder using restoring digit-by-digit iteration, one root bit per clock. It sits beside the squaring block on the same `Input1`/`Start`/`Result` bus style. A controller FSM drives a small shift/subtract datapath.

## Interface
- `WIDTH`, default 8: operand width in bits. Must be even and ≥4. Root width is `WIDTH/2`.
- `clk` input 1: single clock; all state updates on its rising edge.
- `Reset` input 1: synchronous, active-high reset.
- `Start` input 1: request. Sampled only in IDLE or DONE.
- `Input1` input `WIDTH`: two's-complement operand, captured on the accepting edge.
- `Result` output `WIDTH`: floor(sqrt(Input1)), zero-extended from `WIDTH/2` bits.
- `Remainder` output `WIDTH`: Input1 − Result². Present only with `ISQRT_REM_EN`.
- `Busy` output 1: high in ITER.
- `Done` output 1: one-cycle pulse when results are valid.
- `Error` output 1: negative operand. Valid and held with `Done`.

## Operation
- States: IDLE, ITER, DONE. Reset forces IDLE.
- Reset values: `Result`, `Remainder`, `Busy`, `Done`, `Error`, the iteration counter and internal registers are all 0.
- IDLE, `Start`=1 with `Input1[WIDTH-1]`=0:
  - Load operand shift register `x`=Input1, `rem`=0, `root`=0, `cnt`=WIDTH/2−1.
  - Clear `Error`. Go to ITER.
- IDLE, `Start`=1 with `Input1[WIDTH-1]`=1:
  - Set `Error`=1, `Result`=0, `Remainder`=0. Go to DONE.
- ITER, one step per cycle:
  - `r' = {rem, x[WIDTH-1:WIDTH-2]}`; `t = {root, 2'b01}`.
  - If `r' ≥ t` (unsigned): `rem = r' − t`, `root = {root,1}`. Otherwise `rem = r'`, `root = {root,0}`.
  - `x <<= 2`.
- ITER, counter: if `cnt`=0, copy `root`/`rem` to `Result`/`Remainder` and go to DONE. Otherwise `cnt−1`.
- Widths: `rem` and `t` are `WIDTH/2+2` bits. Final remainder ≤ 2·root, so it always fits in `WIDTH/2+1` bits.
- DONE: `Done`=1 for exactly this cycle.
  - If `Start`=1, accept the new operand exactly as in IDLE (back-to-back supported).
  - Otherwise go to IDLE.
- `Start` in ITER is ignored; no queuing.
- `Result`, `Remainder` and `Error` hold their values from DONE until the next accepted `Start` changes them.
- `Reset` mid-iteration aborts immediately: next cycle is IDLE with all outputs 0, and no `Done` is issued.

## Timing
- Accepting edge E (`Start` sampled).
- Non-negative operand: `Busy`=1 during cycles E+1 … E+WIDTH/2. `Done`=1 in cycle E+WIDTH/2+1. For WIDTH=8, `Done` arrives 5 cycles after E.
- Negative operand: `Done`=1 with `Error`=1 in cycle E+1.
- Throughput: one operation per WIDTH/2+1 cycles when `Start` is asserted during DONE.
- `Done`, `Busy`, `Error` and the result outputs are registered; there is no combinational path from inputs to outputs.

## Configuration
- `ISQRT_REM_EN` defined: `Remainder` port exists and is driven as specified.
- `ISQRT_REM_EN` undefined: `Remainder` port and its output register are removed. The internal `rem` still exists because the algorithm needs it. `Result`, `Done` and `Error` behaviour is unchanged.

## Structure
- Package `isqrt_pkg`:
  - state encoding (IDLE=2'd0, ITER=2'd1, DONE=2'd2);
  - `ROOT_W = WIDTH/2`, `REM_W = WIDTH/2+2`;
  - counter width `$clog2(WIDTH/2)`.
- Sub-module `isqrt_datapath`: holds `x`, `rem`, `root`, the trial subtract and the output registers. It is driven by load/step/commit strobes.
- Top `isqrt_seq`: FSM and counter, generating those strobes plus `Busy`/`Done`/`Error`. This mirrors the controller/datapath split used elsewhere in the design.

## Test plan
- Reset held 3 cycles, then `Input1`=100, `Start` 1 cycle → `Done` 5 cycles later with `Result`=10, `Remainder`=0, `Error`=0; `Busy` high for exactly 4 cycles.
- `Input1`=127 → `Result`=11, `Remainder`=6. `Input1`=0 → `Result`=0, `Remainder`=0. `Input1`=1 → `Result`=1, `Remainder`=0.
- `Input1`=8'hFB (−5) → `Done` and `Error`=1 on the next cycle, `Result`=0, `Busy` never asserted.
- `Start` with 64, then `Start` held through ITER → `Start` ignored; `Result`=8. `Start` with 50 during the DONE cycle → second `Done` 5 cycles later with `Result`=7, `Remainder`=1.
- `Reset` pulsed in the 2nd ITER cycle → next cycle IDLE, all outputs 0, no `Done`. A later `Start` with 81 → `Result`=9.
- Exhaustive sweep of `Input1` 0..127, checked against a reference model; repeated with `ISQRT_REM_EN` undefined (`Result` only).

Source files
------------

// File: rtl/isqrt_pkg.sv
// Shared types and width helpers for the sequential integer square root.
// ISQRT_REM_EN adds the Remainder output to isqrt_seq.
package isqrt_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ITER = 2'd1,
        S_DONE = 2'd2
    } state_t;

    function automatic int root_w(input int w);
        return w / 2;
    endfunction

    function automatic int rem_w(input int w);
        return w / 2 + 2;
    endfunction

    function automatic int cnt_w(input int w);
        return (w / 2 > 1) ? $clog2(w / 2) : 1;
    endfunction

endpackage

// File: rtl/isqrt_datapath.sv
// Restoring square-root datapath: operand shifter, trial subtract, output regs.
// ISQRT_REM_EN keeps the remainder output register.
module isqrt_datapath
    import isqrt_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             Reset,
    input  logic             load,
    input  logic             step,
    input  logic             commit,
    input  logic             clear,
    input  logic [WIDTH-1:0] din,
`ifdef ISQRT_REM_EN
    output logic [WIDTH-1:0] remainder,
`endif
    output logic [WIDTH-1:0] result
);

    localparam int ROOT_W = root_w(WIDTH);
    localparam int REM_W  = rem_w(WIDTH);

    logic [WIDTH-1:0]  x;
    logic [REM_W-1:0]  rem;
    logic [ROOT_W-1:0] root;
    logic [REM_W-1:0]  trial;
    logic [REM_W-1:0]  t;
    logic [REM_W-1:0]  rem_nx;
    logic [ROOT_W-1:0] root_nx;
    logic              ge;

    // Bits shifted out of rem are provably zero: rem < 2^ROOT_W when read.
    always_comb begin
        trial   = (rem << 2) | REM_W'(x[WIDTH-1 -: 2]);
        t       = {root, 2'b01};
        ge      = (trial >= t);
        rem_nx  = ge ? (trial - t) : trial;
        root_nx = {root[ROOT_W-2:0], ge};
    end

    always_ff @(posedge clk) begin
        if (Reset) begin
            x    <= '0;
            rem  <= '0;
            root <= '0;
        end else if (load) begin
            x    <= din;
            rem  <= '0;
            root <= '0;
        end else if (step) begin
            x    <= x << 2;
            rem  <= rem_nx;
            root <= root_nx;
        end
    end

    always_ff @(posedge clk) begin
        if (Reset || clear) begin
            result <= '0;
        end else if (commit) begin
            result <= WIDTH'(root_nx);
        end
    end

`ifdef ISQRT_REM_EN
    always_ff @(posedge clk) begin
        if (Reset || clear) begin
            remainder <= '0;
        end else if (commit) begin
            remainder <= WIDTH'(rem_nx);
        end
    end
`endif

endmodule

// File: rtl/isqrt_seq.sv
// Sequential floor square root, one root bit per clock; controller + datapath.
// Define ISQRT_REM_EN to expose the Remainder port.
module isqrt_seq
    import isqrt_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic [WIDTH-1:0] Input1,
    output logic [WIDTH-1:0] Result,
`ifdef ISQRT_REM_EN
    output logic [WIDTH-1:0] Remainder,
`endif
    output logic             Busy,
    output logic             Done,
    output logic             Error
);

    localparam int CNT_W = cnt_w(WIDTH);
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(root_w(WIDTH) - 1);

    state_t           state;
    state_t           state_nx;
    logic [CNT_W-1:0] cnt;
    logic             err;
    logic             load;
    logic             step;
    logic             commit;
    logic             clear;

    always_ff @(posedge clk) begin
        if (Reset) begin
            state <= S_IDLE;
            cnt   <= '0;
            err   <= 1'b0;
        end else begin
            state <= state_nx;
            if (load) begin
                cnt <= CNT_INIT;
                err <= 1'b0;
            end else if (step && cnt != '0) begin
                cnt <= cnt - 1'b1;
            end
            if (clear) begin
                err <= 1'b1;
            end
        end
    end

    // IDLE and DONE accept identically, which gives back-to-back operation.
    always_comb begin
        state_nx = state;
        load     = 1'b0;
        step     = 1'b0;
        commit   = 1'b0;
        clear    = 1'b0;
        unique case (1'b1)
            (state == S_IDLE), (state == S_DONE): begin
                state_nx = S_IDLE;
                if (Start) begin
                    if (Input1[WIDTH-1]) begin
                        clear    = 1'b1;
                        state_nx = S_DONE;
                    end else begin
                        load     = 1'b1;
                        state_nx = S_ITER;
                    end
                end
            end
            (state == S_ITER): begin
                step = 1'b1;
                if (cnt == '0) begin
                    commit   = 1'b1;
                    state_nx = S_DONE;
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    assign Busy  = (state == S_ITER);
    assign Done  = (state == S_DONE);
    assign Error = err;

    isqrt_datapath #(
        .WIDTH(WIDTH)
    ) u_dp (
        .clk      (clk),
        .Reset    (Reset),
        .load     (load),
        .step     (step),
        .commit   (commit),
        .clear    (clear),
        .din      (Input1),
`ifdef ISQRT_REM_EN
        .remainder(Remainder),
`endif
        .result   (Result)
    );

endmodule

// File: tb/tb_isqrt_seq.sv
// Directed and sweep bench for isqrt_seq (WIDTH=8).
// Remainder is checked only when ISQRT_REM_EN is defined.
module tb_isqrt_seq;

    logic       clk = 1'b0;
    logic       Reset;
    logic       Start;
    logic [7:0] Input1;
    logic [7:0] Result;
    logic       Busy;
    logic       Done;
    logic       Error;
`ifdef ISQRT_REM_EN
    logic [7:0] Remainder;
`endif

    always #5 clk = ~clk;

    isqrt_seq #(
        .WIDTH(8)
    ) dut (
        .clk      (clk),
        .Reset    (Reset),
        .Start    (Start),
        .Input1   (Input1),
        .Result   (Result),
`ifdef ISQRT_REM_EN
        .Remainder(Remainder),
`endif
        .Busy     (Busy),
        .Done     (Done),
        .Error    (Error)
    );

    typedef struct {
        logic [7:0] op;
        logic [7:0] res;
        logic [7:0] rem;
        logic       err;
    } vec_t;

    vec_t vecs[16];
    int   tests = 0;
    int   fails = 0;

    task automatic check(input string name, input logic [31:0] got,
                         input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    task automatic check_rem(input string name, input logic [7:0] exp);
`ifdef ISQRT_REM_EN
        check(name, {24'd0, Remainder}, {24'd0, exp});
`else
        if (exp === 8'hxx) $display("unreachable");
`endif
    endtask

    function automatic int isqrt_ref(input int v);
        int r = 0;
        while ((r + 1) * (r + 1) <= v) r++;
        return r;
    endfunction

    task automatic run_op(input logic [7:0] v, input logic [7:0] res,
                          input logic [7:0] rem, input logic err,
                          input string tag);
        int lat    = 0;
        int busy_n = 0;
        @(negedge clk);
        Input1 = v;
        Start  = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            Start = 1'b0;
            if (Busy) busy_n++;
            if (Done) begin
                lat = i;
                break;
            end
        end
        check($sformatf("%s latency", tag), lat, err ? 1 : 5);
        check($sformatf("%s busy", tag), busy_n, err ? 0 : 4);
        check($sformatf("%s result", tag), {24'd0, Result}, {24'd0, res});
        check_rem($sformatf("%s remainder", tag), rem);
        check($sformatf("%s error", tag), {31'd0, Error}, {31'd0, err});
        @(negedge clk);
        check($sformatf("%s done pulse", tag), {31'd0, Done}, 32'd0);
        check($sformatf("%s held", tag), {24'd0, Result}, {24'd0, res});
    endtask

    initial begin
        int lat;
        int r;

        vecs[0]  = '{8'd100, 8'd10, 8'd0,  1'b0};
        vecs[1]  = '{8'hFB,  8'd0,  8'd0,  1'b1};
        vecs[2]  = '{8'd127, 8'd11, 8'd6,  1'b0};
        vecs[3]  = '{8'd0,   8'd0,  8'd0,  1'b0};
        vecs[4]  = '{8'd1,   8'd1,  8'd0,  1'b0};
        vecs[5]  = '{8'd2,   8'd1,  8'd1,  1'b0};
        vecs[6]  = '{8'd3,   8'd1,  8'd2,  1'b0};
        vecs[7]  = '{8'd4,   8'd2,  8'd0,  1'b0};
        vecs[8]  = '{8'd120, 8'd10, 8'd20, 1'b0};
        vecs[9]  = '{8'h80,  8'd0,  8'd0,  1'b1};
        vecs[10] = '{8'd80,  8'd8,  8'd16, 1'b0};
        vecs[11] = '{8'd126, 8'd11, 8'd5,  1'b0};
        vecs[12] = '{8'd99,  8'd9,  8'd18, 1'b0};
        vecs[13] = '{8'd64,  8'd8,  8'd0,  1'b0};
        vecs[14] = '{8'hFF,  8'd0,  8'd0,  1'b1};
        vecs[15] = '{8'd63,  8'd7,  8'd14, 1'b0};

        Reset  = 1'b1;
        Start  = 1'b0;
        Input1 = 8'd0;
        repeat (3) @(negedge clk);
        check("reset result", {24'd0, Result}, 32'd0);
        check_rem("reset remainder", 8'd0);
        check("reset busy", {31'd0, Busy}, 32'd0);
        check("reset done", {31'd0, Done}, 32'd0);
        check("reset error", {31'd0, Error}, 32'd0);
        Reset = 1'b0;

        for (int k = 0; k < 16; k++)
            run_op(vecs[k].op, vecs[k].res, vecs[k].rem, vecs[k].err,
                   $sformatf("vec%0d", k));

        // Start held high through ITER with a different operand
        @(negedge clk);
        Input1 = 8'd64;
        Start  = 1'b1;
        lat    = 0;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            Input1 = 8'd25;
            if (Done) begin
                lat   = i;
                Start = 1'b0;
                break;
            end
        end
        Start = 1'b0;
        check("hold latency", lat, 5);
        check("hold result", {24'd0, Result}, 32'd8);
        @(negedge clk);
        check("hold no restart", {31'd0, Busy}, 32'd0);

        // back-to-back: new Start during the DONE cycle
        @(negedge clk);
        Input1 = 8'd64;
        Start  = 1'b1;
        lat    = 0;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            Start = 1'b0;
            if (Done) begin
                lat    = i;
                Input1 = 8'd50;
                Start  = 1'b1;
                break;
            end
        end
        check("b2b first latency", lat, 5);
        check("b2b first result", {24'd0, Result}, 32'd8);
        lat = 0;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            Start = 1'b0;
            if (Done) begin
                lat = i;
                break;
            end
        end
        check("b2b second latency", lat, 5);
        check("b2b second result", {24'd0, Result}, 32'd7);
        check_rem("b2b second remainder", 8'd1);

        // reset in the second ITER cycle aborts without Done
        @(negedge clk);
        Input1 = 8'd100;
        Start  = 1'b1;
        @(negedge clk);
        Start = 1'b0;
        check("abort busy", {31'd0, Busy}, 32'd1);
        @(negedge clk);
        Reset = 1'b1;
        @(negedge clk);
        check("abort busy low", {31'd0, Busy}, 32'd0);
        check("abort done low", {31'd0, Done}, 32'd0);
        check("abort result", {24'd0, Result}, 32'd0);
        check("abort error", {31'd0, Error}, 32'd0);
        check_rem("abort remainder", 8'd0);
        Reset = 1'b0;
        lat = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (Done || Busy) lat++;
        end
        check("abort quiet", lat, 0);
        run_op(8'd81, 8'd9, 8'd0, 1'b0, "after abort");

        for (int v = 0; v < 128; v++) begin
            r = isqrt_ref(v);
            run_op(8'(v), 8'(r), 8'(v - r * r), 1'b0,
                   $sformatf("sweep %0d", v));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
